// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions used by the register slave and by bus models.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_t;

endpackage

// File: rtl/axi4l_reg_slave_if.sv
// AXI4-Lite bus bundle between the SoC/sim master and the register slave.
// Every channel uses valid/ready: a beat transfers on a rising edge where both are 1;
// once valid is raised its payload stays stable until that edge.
interface axi4l_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  import axi4l_pkg::*;

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  axi4l_resp_t             bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  axi4l_resp_t             rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS RW control words, RO slots served from status_in.
// One outstanding write and one outstanding read; the channels run independently.
module axi4l_reg_slave
  import axi4l_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           axi4l_aclk,
  input  logic                           axi4l_arst,
  axi4l_reg_slave_if.slave               s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic                           o_dbg_wr_busy,
  output logic                           o_dbg_rd_busy
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Returns {in_range, word_index}; the full upper address takes part in the range test.
  function automatic logic [IDX_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word   = addr >> ADDR_LSB;
    decode = {(word < ADDR_WIDTH'(NUM_REGS)), addr[ADDR_LSB +: IDX_W]};
  endfunction

  // ---------------- write channel ----------------
  wr_state_e               r_wr_state;
  wr_state_e               w_wr_next;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_aw_held;
  logic                    r_w_held;
  logic                    r_bvalid;
  axi4l_resp_t             r_bresp;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]     r_wr_strobe;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_commit;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [STRB_W-1:0]       w_wr_strb;
  logic [IDX_W:0]          w_wr_dec;
  logic [IDX_W-1:0]        w_wr_idx;
  logic                    w_wr_ok;

  always_comb begin
    w_aw_hs   = s_axi.awvalid && r_awready;
    w_w_hs    = s_axi.wvalid && r_wready;
    // A beat captured earlier wins over whatever is on the bus now.
    w_wr_addr = r_aw_held ? r_awaddr : s_axi.awaddr;
    w_wr_data = r_w_held ? r_wdata : s_axi.wdata;
    w_wr_strb = r_w_held ? r_wstrb : s_axi.wstrb;
    w_wr_dec  = decode(w_wr_addr);
    w_wr_idx  = w_wr_dec[IDX_W-1:0];
    w_wr_ok   = w_wr_dec[IDX_W] && !RO_MASK[w_wr_idx];
    w_commit  = 1'b0;
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (r_bvalid && s_axi.bready) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge axi4l_aclk) begin
    if (axi4l_arst) r_wr_state <= WR_IDLE;
    else            r_wr_state <= w_wr_next;
  end

  always_ff @(posedge axi4l_aclk) begin
    if (axi4l_arst) begin
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= OKAY;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wr_strobe <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_wr_ok) begin
          r_bresp               <= OKAY;
          r_wr_strobe[w_wr_idx] <= 1'b1;
          for (int j = 0; j < STRB_W; j++) begin
            if (w_wr_strb[j]) r_regs[w_wr_idx][j*8 +: 8] <= w_wr_data[j*8 +: 8];
          end
        end else begin
          r_bresp <= SLVERR;
        end
      end else if (r_wr_state == WR_IDLE) begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi.awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi.wdata;
          r_wstrb  <= s_axi.wstrb;
        end
        r_awready <= !(r_aw_held || w_aw_hs);
        r_wready  <= !(r_w_held || w_w_hs);
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_e             r_rd_state;
  rd_state_e             w_rd_next;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  axi4l_resp_t           r_rresp;

  logic                  w_ar_hs;
  logic [IDX_W:0]        w_rd_dec;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  axi4l_resp_t           w_rd_resp;

  always_comb begin
    w_ar_hs   = s_axi.arvalid && r_arready;
    w_rd_dec  = decode(s_axi.araddr);
    w_rd_idx  = w_rd_dec[IDX_W-1:0];
    w_rd_data = '0;
    w_rd_resp = SLVERR;
    if (w_rd_dec[IDX_W]) begin
      w_rd_resp = OKAY;
      if (RO_MASK[w_rd_idx]) w_rd_data = status_in[int'(w_rd_idx)*DATA_WIDTH +: DATA_WIDTH];
      else                   w_rd_data = r_regs[w_rd_idx];
    end
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs) w_rd_next = RD_DATA;
      RD_DATA: if (r_rvalid && s_axi.rready) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge axi4l_aclk) begin
    if (axi4l_arst) r_rd_state <= RD_IDLE;
    else            r_rd_state <= w_rd_next;
  end

  always_ff @(posedge axi4l_aclk) begin
    if (axi4l_arst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else if (r_rd_state == RD_IDLE) begin
      // Register contents are sampled before any same-edge write lands.
      if (w_ar_hs) begin
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
        r_rdata   <= w_rd_data;
        r_rresp   <= w_rd_resp;
      end else begin
        r_arready <= 1'b1;
      end
    end else if (r_rvalid && s_axi.rready) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign wr_strobe     = r_wr_strobe;
  assign o_dbg_wr_busy = (r_wr_state == WR_RESP);
  assign o_dbg_rd_busy = (r_rd_state == RD_DATA);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
    assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Bench for axi4l_reg_slave: directed corner sequences, a vector table, and randomized
// traffic checked against an array-based register model.
module tb_axi4l_reg_slave;
  import axi4l_pkg::*;

  localparam int              NR = 16;
  localparam int              DW = 32;
  localparam logic [NR-1:0]   RO = 16'h8004;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR*DW-1:0]     ctrl_out;
  logic [NR*DW-1:0]     status_in;
  logic [NR-1:0]        wr_strobe;
  logic                 dbg_wr_busy;
  logic                 dbg_rd_busy;
  int                   n_checks = 0;
  int                   n_fail = 0;
  logic [DW-1:0]        model_regs [NR];

  axi4l_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) m ();

  axi4l_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .axi4l_aclk   (clk),
    .axi4l_arst   (rst),
    .s_axi        (m),
    .ctrl_out     (ctrl_out),
    .status_in    (status_in),
    .wr_strobe    (wr_strobe),
    .o_dbg_wr_busy(dbg_wr_busy),
    .o_dbg_rd_busy(dbg_rd_busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [NR*DW-1:0] model_ctrl();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model_regs[i];
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output axi4l_resp_t resp, output logic [NR-1:0] strobe);
    int word;
    word   = int'(a >> 2);
    strobe = '0;
    resp   = SLVERR;
    if (word < NR && !RO[word]) begin
      for (int j = 0; j < 4; j++) if (s[j]) model_regs[word][j*8 +: 8] = d[j*8 +: 8];
      strobe       = '0;
      strobe[word] = 1'b1;
      resp         = OKAY;
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output axi4l_resp_t resp);
    int word;
    word = int'(a >> 2);
    d    = '0;
    resp = SLVERR;
    if (word < NR) begin
      resp = OKAY;
      d    = RO[word] ? status_in[word*DW +: DW] : model_regs[word];
    end
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) return 32'h100 | lo;
    return (32'($urandom_range(0, 17)) << 2) | lo;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_aw(input logic [31:0] a, input int dly, output longint t);
    bit hs = 0;
    repeat (dly) tick();
    m.awaddr  = a;
    m.awvalid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      hs = m.awready;
      tick();
    end
    m.awvalid = 1'b0;
    t = $time;
    check("aw_accept", hs, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output longint t);
    bit hs = 0;
    repeat (dly) tick();
    m.wdata  = d;
    m.wstrb  = s;
    m.wvalid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      hs = m.wready;
      tick();
    end
    m.wvalid = 1'b0;
    t = $time;
    check("w_accept", hs, 1);
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly, output longint t);
    bit hs = 0;
    repeat (dly) tick();
    m.araddr  = a;
    m.arvalid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      hs = m.arready;
      tick();
    end
    m.arvalid = 1'b0;
    t = $time;
    check("ar_accept", hs, 1);
  endtask

  task automatic wait_b(input int dly, output axi4l_resp_t resp);
    bit seen = 0;
    axi4l_resp_t r0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (m.bvalid) seen = 1;
      else tick();
    end
    check("b_arrive", seen, 1);
    r0 = m.bresp;
    repeat (dly) tick();
    check("b_stable", {m.bvalid, m.bresp}, {1'b1, r0});
    resp    = m.bresp;
    m.bready = 1'b1;
    tick();
    m.bready = 1'b0;
    check("b_single", m.bvalid, 0);
  endtask

  task automatic wait_r(input int dly, output logic [31:0] d, output axi4l_resp_t resp);
    bit seen = 0;
    logic [33:0] r0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (m.rvalid) seen = 1;
      else tick();
    end
    check("r_arrive", seen, 1);
    r0 = {m.rresp, m.rdata};
    repeat (dly) tick();
    check("r_stable", {m.rvalid, m.rresp, m.rdata}, {1'b1, r0});
    d       = m.rdata;
    resp    = m.rresp;
    m.rready = 1'b1;
    tick();
    m.rready = 1'b0;
    check("r_single", m.rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output axi4l_resp_t resp, output logic [NR-1:0] strobe, output longint t_c);
    longint ta, tw;
    fork
      send_aw(a, aw_dly, ta);
      send_w(d, s, w_dly, tw);
    join
    strobe = wr_strobe;
    t_c    = (ta > tw) ? ta : tw;
    wait_b(b_dly, resp);
  endtask

  task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                         output logic [31:0] d, output axi4l_resp_t resp, output longint t_ar);
    send_ar(a, ar_dly, t_ar);
    wait_r(r_dly, d, resp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            wr;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    axi4l_resp_t   resp;
    logic [31:0]   val;     // rdata for reads, ctrl_out slot (addr>>2)%16 after writes
    logic [NR-1:0] strobe;
  } vec_t;

  vec_t vecs[13];

  initial begin
    axi4l_resp_t   resp, exp_resp, old_r, new_r;
    logic [31:0]   rd, old_d, new_d, addr, data;
    logic [3:0]    strb;
    logic [NR-1:0] strobe, exp_strobe;
    longint        t_c, t_ar;
    int            op;

    vecs[0]  = '{1'b1, 32'h100, 32'h11111111, 4'hF, SLVERR, 32'h0,        16'h0000};
    vecs[1]  = '{1'b1, 32'h08,  32'hFFFFFFFF, 4'hF, SLVERR, 32'h0,        16'h0000};
    vecs[2]  = '{1'b0, 32'h100, 32'h0,        4'h0, SLVERR, 32'h0,        16'h0000};
    vecs[3]  = '{1'b1, 32'h0C,  32'hA5A5A5A5, 4'h6, OKAY,   32'h00A5A500, 16'h0008};
    vecs[4]  = '{1'b1, 32'h0C,  32'hFFFFFFFF, 4'h0, OKAY,   32'h00A5A500, 16'h0008};
    vecs[5]  = '{1'b0, 32'h0C,  32'h0,        4'h0, OKAY,   32'h00A5A500, 16'h0000};
    vecs[6]  = '{1'b1, 32'h3D,  32'h55555555, 4'hF, SLVERR, 32'h0,        16'h0000};
    vecs[7]  = '{1'b0, 32'h3F,  32'h0,        4'h0, OKAY,   32'hCAFEF00D, 16'h0000};
    vecs[8]  = '{1'b1, 32'h39,  32'h01020304, 4'hF, OKAY,   32'h01020304, 16'h4000};
    vecs[9]  = '{1'b0, 32'h38,  32'h0,        4'h0, OKAY,   32'h01020304, 16'h0000};
    vecs[10] = '{1'b0, 32'h04,  32'h0,        4'h0, OKAY,   32'hDEADBEAA, 16'h0000};
    vecs[11] = '{1'b0, 32'h40,  32'h0,        4'h0, SLVERR, 32'h0,        16'h0000};
    vecs[12] = '{1'b0, 32'h0A,  32'h0,        4'h0, OKAY,   32'h12345678, 16'h0000};

    for (int i = 0; i < NR; i++) begin
      status_in[i*DW +: DW] = $urandom();
      model_regs[i] = '0;
    end
    status_in[2*DW +: DW]  = 32'h12345678;
    status_in[15*DW +: DW] = 32'hCAFEF00D;
    m.awaddr = '0; m.awvalid = 0; m.wdata = '0; m.wstrb = '0; m.wvalid = 0; m.bready = 0;
    m.araddr = '0; m.arvalid = 0; m.rready = 0;

    // ---- reset: held 3 cycles, readies rise one edge after release ----
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("reset_idle", {m.awready, m.wready, m.arready, m.bvalid, m.rvalid, wr_strobe}, 0);
    end
    check("reset_ctrl", ctrl_out, 0);
    check("reset_resp", {m.bresp, m.rresp, m.rdata}, 0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", {m.awready, m.wready, m.arready, m.bvalid, m.rvalid}, 5'b11100);

    // ---- AW and W in the same cycle ----
    m.awaddr = 32'h04; m.awvalid = 1; m.wdata = 32'hDEADBEEF; m.wstrb = 4'hF; m.wvalid = 1;
    tick();
    m.awvalid = 0; m.wvalid = 0;
    check("wr1_bvalid", {m.bvalid, m.bresp}, {1'b1, 2'b00});
    check("wr1_ctrl", ctrl_out[1*DW +: DW], 32'hDEADBEEF);
    check("wr1_strobe", wr_strobe, 16'h0002);
    check("wr1_ready_low", {m.awready, m.wready}, 2'b00);
    model_regs[1] = 32'hDEADBEEF;
    tick();
    check("wr1_strobe_pulse", wr_strobe, 16'h0000);
    check("wr1_b_hold", {m.bvalid, m.bresp}, {1'b1, 2'b00});
    m.bready = 1;
    tick();
    m.bready = 0;
    check("wr1_b_done", {m.bvalid, m.awready, m.wready}, 3'b011);

    // ---- W three cycles ahead of AW ----
    m.wdata = 32'h000000AA; m.wstrb = 4'h1; m.wvalid = 1;
    tick();
    m.wvalid = 0;
    check("wfirst_held", {m.awready, m.wready, m.bvalid}, 3'b100);
    repeat (2) begin
      tick();
      check("wfirst_aw_ready", {m.awready, m.wready, m.bvalid}, 3'b100);
    end
    m.awaddr = 32'h04; m.awvalid = 1;
    tick();
    m.awvalid = 0;
    check("wfirst_commit", {m.bvalid, m.bresp}, {1'b1, 2'b00});
    check("wfirst_ctrl", ctrl_out[1*DW +: DW], 32'hDEADBEAA);
    check("wfirst_strobe", wr_strobe, 16'h0002);
    model_regs[1] = 32'hDEADBEAA;
    m.bready = 1;
    tick();
    m.bready = 0;

    // ---- RO read with rready held off 5 cycles ----
    m.araddr = 32'h08; m.arvalid = 1;
    tick();
    m.arvalid = 0;
    check("ro_rd_first", {m.rvalid, m.arready, m.rresp, m.rdata}, {1'b1, 1'b0, 2'b00, 32'h12345678});
    repeat (5) begin
      tick();
      check("ro_rd_hold", {m.rvalid, m.rresp, m.rdata}, {1'b1, 2'b00, 32'h12345678});
    end
    m.rready = 1;
    tick();
    m.rready = 0;
    check("ro_rd_done", {m.rvalid, m.arready}, 2'b01);

    // ---- vector table ----
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, strobe, t_c);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, exp_resp, exp_strobe);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_strobe", i), strobe, vecs[i].strobe);
        check($sformatf("vec%0d_slot", i), ctrl_out[((vecs[i].addr >> 2) & 32'hF)*DW +: DW], vecs[i].val);
        check($sformatf("vec%0d_ctrl", i), ctrl_out, model_ctrl());
      end else begin
        do_read(vecs[i].addr, 0, 0, rd, resp, t_ar);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].val);
      end
    end

    // ---- reset mid-transaction drops the captured W beat ----
    m.wdata = 32'h77777777; m.wstrb = 4'hF; m.wvalid = 1;
    tick();
    m.wvalid = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    check("midrst_ready", {m.awready, m.wready, m.arready, m.bvalid}, 4'b1110);
    check("midrst_ctrl", ctrl_out, 0);
    m.awaddr = 32'h0C; m.awvalid = 1;
    tick();
    m.awvalid = 0;
    tick();
    check("midrst_no_commit", m.bvalid, 0);
    send_w(32'h00000001, 4'h1, 0, t_c);
    wait_b(0, resp);
    model_write(32'h0C, 32'h00000001, 4'h1, exp_resp, exp_strobe);
    check("midrst_bresp", resp, exp_resp);
    check("midrst_ctrl_after", ctrl_out, model_ctrl());

    // ---- randomized traffic against the model ----
    for (int it = 0; it < 150; it++) begin
      op   = $urandom_range(0, 2);
      addr = gen_addr();
      data = $urandom();
      strb = 4'($urandom_range(0, 15));
      if (op == 0) begin
        do_write(addr, data, strb, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 resp, strobe, t_c);
        model_write(addr, data, strb, exp_resp, exp_strobe);
        check("rnd_bresp", resp, exp_resp);
        check("rnd_strobe", strobe, exp_strobe);
        check("rnd_ctrl", ctrl_out, model_ctrl());
      end else if (op == 1) begin
        do_read(addr, $urandom_range(0, 4), $urandom_range(0, 4), rd, resp, t_ar);
        model_read(addr, old_d, old_r);
        check("rnd_rresp", resp, old_r);
        check("rnd_rdata", rd, old_d);
      end else begin
        if ($urandom_range(0, 1) == 1) addr = 32'h04;
        model_read(addr, old_d, old_r);
        fork
          do_write(addr, data, strb, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                   resp, strobe, t_c);
          do_read(addr, $urandom_range(0, 4), $urandom_range(0, 4), rd, new_r, t_ar);
        join
        model_write(addr, data, strb, exp_resp, exp_strobe);
        model_read(addr, new_d, old_r);
        // A read accepted on or before the commit edge sees the pre-write contents.
        check("cc_bresp", resp, exp_resp);
        check("cc_strobe", strobe, exp_strobe);
        check("cc_rresp", new_r, old_r);
        check("cc_rdata", rd, (t_ar <= t_c) ? old_d : new_d);
        check("cc_ctrl", ctrl_out, model_ctrl());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
